// File: rtl/acmd12_cmd_arbiter.sv
// acmd12_cmd_arbiter: arbitrates driver commands and Auto CMD12 onto the SD command line and classifies their errors
module acmd12_cmd_arbiter #(
  parameter logic [31:0] Cmd12Arg      = 32'h0,
  parameter logic [1:0]  Cmd12RespType = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        drv_valid_i,
  output logic        drv_ready_o,
  input  logic [5:0]  drv_index_i,
  input  logic [31:0] drv_arg_i,
  input  logic [1:0]  drv_resp_type_i,
  input  logic        drv_crc_chk_i,
  input  logic        drv_idx_chk_i,
  input  logic        acmd12_req_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_resp_type_o,
  output logic        cmd_crc_chk_o,
  output logic        cmd_idx_chk_o,
  input  logic        rsp_done_i,
  input  logic [3:0]  rsp_err_i,
  output logic        drv_complete_o,
  output logic [3:0]  drv_err_o,
  output logic        acmd12_complete_o,
  output logic [7:0]  acmd12_err_o,
  input  logic [7:0]  acmd12_err_clr_i,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, ISSUE_A12, WAIT_A12, ISSUE_DRV, WAIT_DRV} state_t;

  state_t      state_q, state_d;
  logic        a12_pend_q, a12_pend_d, drv_pend_q, drv_pend_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  rt_q, rt_d;
  logic        crc_q, crc_d, ichk_q, ichk_d;
  logic [7:0]  err_q, err_d;
  logic        is_a12, is_drv, accept, done_a12, done_drv, fail, drop_drv, drop_a12;

  assign is_a12   = !rst_i && state_q == ISSUE_A12;
  assign is_drv   = !rst_i && state_q == ISSUE_DRV;
  assign accept   = drv_valid_i && drv_ready_o;
  assign done_a12 = !rst_i && rsp_done_i && state_q == WAIT_A12;
  assign done_drv = !rst_i && rsp_done_i && state_q == WAIT_DRV;
  assign fail     = rsp_err_i != 4'h0;
  assign drop_drv = done_a12 && fail && drv_pend_q;
  assign drop_a12 = done_drv && fail && a12_pend_q;

  assign drv_ready_o       = !rst_i && !drv_pend_q && state_q != WAIT_DRV;
  assign cmd_valid_o       = is_a12 || is_drv;
  assign cmd_index_o       = is_a12 ? 6'd12 : is_drv ? idx_q : 6'd0;
  assign cmd_arg_o         = is_a12 ? Cmd12Arg : is_drv ? arg_q : 32'h0;
  assign cmd_resp_type_o   = is_a12 ? Cmd12RespType : is_drv ? rt_q : 2'b00;
  assign cmd_crc_chk_o     = is_a12 || (is_drv && crc_q);
  assign cmd_idx_chk_o     = is_a12 || (is_drv && ichk_q);
  assign drv_complete_o    = done_drv;
  assign drv_err_o         = done_drv ? rsp_err_i : 4'h0;
  assign acmd12_complete_o = done_a12;
  assign acmd12_err_o      = rst_i ? 8'h00 : err_q;
  assign busy_o            = !rst_i && (drv_pend_q || a12_pend_q || state_q != IDLE);

  // next-state: CMD12 wins arbitration; an issued command waits for its response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = a12_pend_q ? ISSUE_A12 : drv_pend_q ? ISSUE_DRV : IDLE;
      ISSUE_A12: state_d = cmd_ready_i ? WAIT_A12 : ISSUE_A12;
      ISSUE_DRV: state_d = cmd_ready_i ? WAIT_DRV : ISSUE_DRV;
      WAIT_A12:  state_d = rsp_done_i ? IDLE : WAIT_A12;
      WAIT_DRV:  state_d = rsp_done_i ? IDLE : WAIT_DRV;
      default:   state_d = IDLE;
    endcase
  end

  // pending flags, captured driver fields and the sticky CMD12 error status
  always_comb begin
    a12_pend_d = (a12_pend_q || (acmd12_req_i && state_q != ISSUE_A12 && state_q != WAIT_A12))
                 && !(state_q == ISSUE_A12 && cmd_ready_i) && !drop_a12;
    drv_pend_d = (drv_pend_q || accept) && !(state_q == ISSUE_DRV && cmd_ready_i) && !drop_drv;
    idx_d      = accept ? drv_index_i : idx_q;
    arg_d      = accept ? drv_arg_i : arg_q;
    rt_d       = accept ? drv_resp_type_i : rt_q;
    crc_d      = accept ? drv_crc_chk_i : crc_q;
    ichk_d     = accept ? drv_idx_chk_i : ichk_q;
    err_d      = (err_q & ~acmd12_err_clr_i)
                 | (done_a12 ? {drop_drv, 2'b00, rsp_err_i, 1'b0} : 8'h00)
                 | {7'h00, drop_a12};
  end

  // state registers; reset abandons everything silently
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a12_pend_q <= 1'b0;
      drv_pend_q <= 1'b0;
      idx_q      <= 6'd0;
      arg_q      <= 32'h0;
      rt_q       <= 2'b00;
      crc_q      <= 1'b0;
      ichk_q     <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      a12_pend_q <= a12_pend_d;
      drv_pend_q <= drv_pend_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      rt_q       <= rt_d;
      crc_q      <= crc_d;
      ichk_q     <= ichk_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_acmd12_cmd_arbiter.sv
// tb_acmd12_cmd_arbiter: scenario table, directed corner cases and randomized run against a transaction-level model
module tb_acmd12_cmd_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        drv_valid_i = 1'b0, drv_ready_o;
  logic [5:0]  drv_index_i = '0;
  logic [31:0] drv_arg_i = '0;
  logic [1:0]  drv_resp_type_i = '0;
  logic        drv_crc_chk_i = 1'b0, drv_idx_chk_i = 1'b0, acmd12_req_i = 1'b0;
  logic        cmd_valid_o, cmd_ready_i = 1'b0;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_resp_type_o;
  logic        cmd_crc_chk_o, cmd_idx_chk_o, rsp_done_i = 1'b0;
  logic [3:0]  rsp_err_i = '0, drv_err_o;
  logic        drv_complete_o, acmd12_complete_o, busy_o;
  logic [7:0]  acmd12_err_o, acmd12_err_clr_i = '0;

  always #5 clk_i = ~clk_i;

  acmd12_cmd_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .drv_valid_i(drv_valid_i), .drv_ready_o(drv_ready_o),
    .drv_index_i(drv_index_i), .drv_arg_i(drv_arg_i), .drv_resp_type_i(drv_resp_type_i),
    .drv_crc_chk_i(drv_crc_chk_i), .drv_idx_chk_i(drv_idx_chk_i), .acmd12_req_i(acmd12_req_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_index_o(cmd_index_o),
    .cmd_arg_o(cmd_arg_o), .cmd_resp_type_o(cmd_resp_type_o), .cmd_crc_chk_o(cmd_crc_chk_o),
    .cmd_idx_chk_o(cmd_idx_chk_o), .rsp_done_i(rsp_done_i), .rsp_err_i(rsp_err_i),
    .drv_complete_o(drv_complete_o), .drv_err_o(drv_err_o), .acmd12_complete_o(acmd12_complete_o),
    .acmd12_err_o(acmd12_err_o), .acmd12_err_clr_i(acmd12_err_clr_i), .busy_o(busy_o)
  );

  int total = 0, bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transaction-level model: what is pending, what is on the wire, sticky status
  bit          m_a12, m_drv;
  int          m_infl;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  logic [1:0]  m_rt;
  logic        m_crc, m_ichk;
  logic [7:0]  m_err;

  // transmitter stand-in and per-test recording
  int          cnt, xm_lat = 8;
  bit          cur12, rnd_err, clr_on_done;
  logic [3:0]  ea, ed, dd_err;
  logic [7:0]  clr_val = 8'h00;
  int          n12, ndrv, n_ad, n_dd;
  bit          got_first, s_busy, s_valid, s_ready;
  logic [5:0]  first_idx, s_idx, last_drv_idx;
  logic [31:0] s_arg, last_drv_arg;
  logic [1:0]  s_rt;
  logic        s_crc, s_ichk;
  logic [7:0]  s_aerr;

  task automatic clear_rec();
    n12 = 0; ndrv = 0; n_ad = 0; n_dd = 0; got_first = 0; dd_err = 0; first_idx = 0;
  endtask

  task automatic model_check();
    bit legal;
    check("busy", busy_o, m_a12 || m_drv || m_infl != 0);
    check("drv_ready", drv_ready_o, !m_drv && m_infl != 2);
    check("a12_complete", acmd12_complete_o, rsp_done_i && m_infl == 1);
    check("drv_complete", drv_complete_o, rsp_done_i && m_infl == 2);
    check("drv_err", drv_err_o, (rsp_done_i && m_infl == 2) ? rsp_err_i : 4'h0);
    check("a12_err", acmd12_err_o, m_err);
    if (cmd_valid_o) begin
      legal = m_infl == 0 && (cmd_index_o == 6'd12
        ? m_a12 && cmd_arg_o == 32'h0 && cmd_resp_type_o == 2'b11 && cmd_crc_chk_o && cmd_idx_chk_o
        : m_drv && cmd_index_o == m_idx && cmd_arg_o == m_arg && cmd_resp_type_o == m_rt
          && cmd_crc_chk_o == m_crc && cmd_idx_chk_o == m_ichk);
      check("cmd_legal", legal, 1);
    end
  endtask

  task automatic model_update();
    bit hs, pres12, drop_d, drop_a, acc, req;
    logic [7:0] set;
    hs = cmd_valid_o && cmd_ready_i;
    pres12 = cmd_valid_o && cmd_index_o == 6'd12;
    drop_d = rsp_done_i && m_infl == 1 && rsp_err_i != 0 && m_drv;
    drop_a = rsp_done_i && m_infl == 2 && rsp_err_i != 0 && m_a12;
    acc = drv_valid_i && !m_drv && m_infl != 2;
    req = acmd12_req_i && m_infl != 1 && !pres12;
    set = (rsp_done_i && m_infl == 1) ? {3'b000, rsp_err_i, 1'b0} : 8'h00;
    if (drop_d) set = set | 8'h80;
    if (drop_a) set = set | 8'h01;
    m_err = (m_err & ~acmd12_err_clr_i) | set;
    if (rsp_done_i) m_infl = 0;
    if (hs && pres12) begin m_a12 = 0; m_infl = 1; end
    if (hs && !pres12) begin m_drv = 0; m_infl = 2; end
    if (acc) begin
      m_drv = 1; m_idx = drv_index_i; m_arg = drv_arg_i; m_rt = drv_resp_type_i;
      m_crc = drv_crc_chk_i; m_ichk = drv_idx_chk_i;
    end
    if (req) m_a12 = 1;
    if (drop_d) m_drv = 0;
    if (drop_a) m_a12 = 0;
  endtask

  task automatic cycle();
    rsp_done_i = cnt == 1;
    rsp_err_i = rsp_done_i ? (cur12 ? ea : ed) : 4'h0;
    acmd12_err_clr_i = (clr_on_done && rsp_done_i) ? 8'hFF : clr_val;
    @(negedge clk_i);
    s_busy = busy_o; s_valid = cmd_valid_o; s_ready = drv_ready_o; s_idx = cmd_index_o;
    s_arg = cmd_arg_o; s_rt = cmd_resp_type_o; s_crc = cmd_crc_chk_o; s_ichk = cmd_idx_chk_o;
    s_aerr = acmd12_err_o;
    if (rst_i) begin
      check("reset_outputs", {drv_ready_o, cmd_valid_o, drv_complete_o, acmd12_complete_o, busy_o,
        cmd_crc_chk_o, cmd_idx_chk_o, cmd_resp_type_o, drv_err_o, acmd12_err_o, cmd_index_o, cmd_arg_o}, 0);
      m_a12 = 0; m_drv = 0; m_infl = 0; m_err = 0; cnt = 0;
    end else begin
      model_check();
      if (drv_complete_o) begin n_dd++; dd_err = dd_err | drv_err_o; end
      if (acmd12_complete_o) n_ad++;
      if (cnt > 0) cnt--;
      if (cmd_valid_o && cmd_ready_i) begin
        cur12 = cmd_index_o == 6'd12;
        if (rnd_err) begin
          xm_lat = $urandom_range(1, 6);
          ea = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
          ed = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        end
        cnt = xm_lat;
        if (cur12) n12++;
        else begin ndrv++; last_drv_idx = cmd_index_o; last_drv_arg = cmd_arg_o; end
        if (!got_first) begin got_first = 1; first_idx = cmd_index_o; end
      end
      model_update();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(string nm);
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (!s_busy) break;
    end
    check(nm, s_busy, 0);
  endtask

  typedef struct {
    int d_at; int a_at; logic [3:0] ea; logic [3:0] ed;
    logic [5:0] first; int n12; int ndrv; int n_ad; int n_dd; logic [3:0] derr; logic [7:0] aerr;
  } scn_t;
  scn_t scn [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    scn[0] = '{1, 1, 4'h0, 4'h0, 6'd12, 1, 1, 1, 1, 4'h0, 8'h00};
    scn[1] = '{1, 1, 4'hA, 4'h0, 6'd12, 1, 0, 1, 0, 4'h0, 8'h94};
    scn[2] = '{0, 5, 4'h0, 4'hA, 6'd18, 0, 1, 0, 1, 4'hA, 8'h01};
    scn[3] = '{0, -1, 4'h0, 4'h1, 6'd18, 0, 1, 0, 1, 4'h1, 8'h00};
    scn[4] = '{-1, 0, 4'h1, 4'h0, 6'd12, 1, 0, 1, 0, 4'h0, 8'h02};
    scn[5] = '{0, 5, 4'h0, 4'h0, 6'd18, 1, 1, 1, 1, 4'h0, 8'h00};
    scn[6] = '{1, 1, 4'h0, 4'h8, 6'd12, 1, 1, 1, 1, 4'h8, 8'h00};
    scn[7] = '{2, 0, 4'h4, 4'h0, 6'd12, 1, 0, 1, 0, 4'h0, 8'h88};

    rst_i = 1;
    repeat (3) cycle();
    rst_i = 0;
    cycle();
    check("reset_idle", {s_busy, s_ready, s_aerr}, {1'b0, 1'b1, 8'h00});

    // scenario table
    for (int i = 0; i < 8; i++) begin
      clear_rec();
      ea = scn[i].ea; ed = scn[i].ed; xm_lat = 8; cmd_ready_i = 1;
      for (int c = 0; c < 200; c++) begin
        drv_valid_i = c == scn[i].d_at;
        drv_index_i = 6'd18; drv_arg_i = 32'hCAFE_0000 + 32'(i); drv_resp_type_i = 2'b01;
        drv_crc_chk_i = 1; drv_idx_chk_i = 0;
        acmd12_req_i = c == scn[i].a_at;
        cycle();
        if (c > scn[i].d_at + 1 && c > scn[i].a_at + 1 && !s_busy) break;
      end
      drv_valid_i = 0; acmd12_req_i = 0;
      check($sformatf("scn%0d_idle", i), s_busy, 0);
      check($sformatf("scn%0d_first", i), first_idx, scn[i].first);
      check($sformatf("scn%0d_counts", i), {8'(n12), 8'(ndrv), 8'(n_ad), 8'(n_dd)},
            {8'(scn[i].n12), 8'(scn[i].ndrv), 8'(scn[i].n_ad), 8'(scn[i].n_dd)});
      check($sformatf("scn%0d_drv_err", i), dd_err, scn[i].derr);
      check($sformatf("scn%0d_a12_err", i), s_aerr, scn[i].aerr);
      if (ndrv > 0) check($sformatf("scn%0d_drv_fields", i), {last_drv_idx, last_drv_arg}, {6'd18, 32'hCAFE_0000 + 32'(i)});
      clr_val = 8'hFF; cycle(); clr_val = 8'h00; cycle();
      check($sformatf("scn%0d_cleared", i), s_aerr, 0);
    end

    // transmitter stalls a CMD12 for 20 cycles
    begin
      logic [40:0] snap;
      int stable_bad;
      bit rdy3, rdy5;
      clear_rec(); cmd_ready_i = 0; xm_lat = 3; ea = 0; ed = 0; stable_bad = 0;
      acmd12_req_i = 1; cycle(); acmd12_req_i = 0;
      for (int k = 0; k < 10 && !s_valid; k++) cycle();
      check("stall_present", {s_valid, s_idx}, {1'b1, 6'd12});
      snap = {s_idx, s_arg, s_rt, s_crc, s_ichk};
      for (int k = 0; k < 20; k++) begin
        drv_valid_i = k >= 3;
        drv_index_i = k == 3 ? 6'd20 : 6'd33;
        drv_arg_i = k == 3 ? 32'h1111 : 32'h2222;
        cycle();
        if (!s_valid || {s_idx, s_arg, s_rt, s_crc, s_ichk} != snap) stable_bad++;
        if (k == 3) rdy3 = s_ready;
        if (k == 5) rdy5 = s_ready;
      end
      check("stall_stable", stable_bad, 0);
      check("stall_first_accept", rdy3, 1);
      check("stall_second_blocked", rdy5, 0);
      drv_valid_i = 0; cmd_ready_i = 1;
      drain("stall_drain");
      check("stall_order", {8'(n12), 8'(ndrv), last_drv_idx, last_drv_arg}, {8'd1, 8'd1, 6'd20, 32'h1111});
    end

    // clear landing in the same cycle as a new timeout error
    clear_rec(); ea = 4'h8;
    acmd12_req_i = 1; cycle(); acmd12_req_i = 0;
    drain("clr_drain1");
    check("clr_pre", s_aerr, 8'h10);
    ea = 4'h1; clr_on_done = 1;
    acmd12_req_i = 1; cycle(); acmd12_req_i = 0;
    drain("clr_drain2");
    clr_on_done = 0;
    check("clr_same_cycle", s_aerr, 8'h02);
    clr_val = 8'hFF; cycle(); clr_val = 8'h00; cycle();
    check("clr_after", s_aerr, 8'h00);

    // reset while a driver command is in flight and CMD12 is pending
    clear_rec(); xm_lat = 10; ed = 0; ea = 0;
    drv_valid_i = 1; drv_index_i = 6'd18; cycle(); drv_valid_i = 0;
    for (int k = 0; k < 10 && ndrv == 0; k++) cycle();
    acmd12_req_i = 1; cycle(); acmd12_req_i = 0;
    cycle();
    check("rst_pre_busy", s_busy, 1);
    rst_i = 1; cycle(); rst_i = 0;
    clear_rec();
    cycle();
    check("rst_after", {s_busy, s_valid}, 0);
    repeat (12) cycle();
    check("rst_no_activity", {8'(n12), 8'(ndrv), 8'(n_ad), 8'(n_dd)}, 0);

    // randomized traffic against the model
    rnd_err = 1;
    for (int k = 0; k < 3000; k++) begin
      drv_valid_i = $urandom_range(0, 3) == 0;
      drv_index_i = 6'($urandom_range(0, 62));
      if (drv_index_i == 6'd12) drv_index_i = 6'd13;
      drv_arg_i = $urandom; drv_resp_type_i = 2'($urandom_range(0, 3));
      drv_crc_chk_i = 1'($urandom_range(0, 1)); drv_idx_chk_i = 1'($urandom_range(0, 1));
      cmd_ready_i = $urandom_range(0, 2) != 0;
      acmd12_req_i = $urandom_range(0, 7) == 0 && cnt != 1;
      clr_val = $urandom_range(0, 15) == 0 ? 8'($urandom) : 8'h00;
      cycle();
    end
    drv_valid_i = 0; acmd12_req_i = 0; clr_val = 0; cmd_ready_i = 1;
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
